// File: rtl/store_unit.sv
// store_unit: narrows a register value to byte/half/word, places it on the
// correct byte lanes of the data-memory write port and issues one or two
// word-aligned beats (two when a misaligned store crosses a word boundary).
module store_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        DONE
    } state_t;

    state_t      state;

    logic [31:0] b1_addr;
    logic [31:0] b1_data;
    logic [3:0]  b1_strb;
    logic        need_b1;

    logic [31:0] narrow;
    logic [3:0]  mask;
    logic        size_bad;
    logic [63:0] wide_data;
    logic [7:0]  wide_strb;
    logic        crosses;
    logic        reject;
    logic [31:0] base_addr;

    assign req_ready = (state == IDLE);

    // Lane math on the live request: narrow, then shift data and strobes across a 64-bit window
    always_comb begin
        narrow   = '0;
        mask     = '0;
        size_bad = 1'b0;
        case (req_size)
            2'b00: begin
                narrow = {24'b0, req_data[7:0]};
                mask   = 4'b0001;
            end
            2'b01: begin
                narrow = {16'b0, req_data[15:0]};
                mask   = 4'b0011;
            end
            2'b10: begin
                narrow = req_data;
                mask   = 4'b1111;
            end
            default: begin
                size_bad = 1'b1;
            end
        endcase
        wide_data = {32'b0, narrow} << {req_addr[1:0], 3'b000};
        wide_strb = {4'b0, mask} << req_addr[1:0];
        crosses   = |wide_strb[7:4];
        reject    = size_bad || (crosses && (SPLIT_EN == 1'b0));
        base_addr = {req_addr[31:2], 2'b00};
    end

    // Store sequencer: accept, issue beat0 and optional beat1, then pulse done (with err on rejection)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            b1_addr   <= '0;
            b1_data   <= '0;
            b1_strb   <= '0;
            need_b1   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req_valid) begin
                        if (reject) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= base_addr;
                            mem_wdata <= wide_data[31:0];
                            mem_wstrb <= wide_strb[3:0];
                            b1_addr   <= base_addr + 32'd4;
                            b1_data   <= wide_data[63:32];
                            b1_strb   <= wide_strb[7:4];
                            need_b1   <= crosses;
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (need_b1) begin
                            state     <= BEAT1;
                            mem_addr  <= b1_addr;
                            mem_wdata <= b1_data;
                            mem_wstrb <= b1_strb;
                        end else begin
                            state     <= DONE;
                            mem_valid <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                            done      <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        state     <= DONE;
                        mem_valid <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed scoreboard bench for store_unit. Expected beats and
// done/err outcomes are queued when a store is driven and popped as the DUT
// produces them. A second instance with SPLIT_EN = 0 covers the reject path.
module tb_store_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        mem_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        req_valid_a;
    logic        req_valid_b;
    logic        use_b;

    logic        a_req_ready, a_mem_valid, a_done, a_err;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wstrb;
    logic        b_req_ready, b_mem_valid, b_done, b_err;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wstrb;

    logic        o_req_ready, o_mem_valid, o_done, o_err;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;

    beat_t       beat_q[$];
    logic        err_q[$];
    int          compared;
    int          mismatched;

    store_unit #(.SPLIT_EN(1'b1)) u_split (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_a),
        .req_ready (a_req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (a_mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (a_mem_addr),
        .mem_wdata (a_mem_wdata),
        .mem_wstrb (a_mem_wstrb),
        .done      (a_done),
        .err       (a_err)
    );

    store_unit #(.SPLIT_EN(1'b0)) u_nosplit (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_b),
        .req_ready (b_req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (b_mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (b_mem_addr),
        .mem_wdata (b_mem_wdata),
        .mem_wstrb (b_mem_wstrb),
        .done      (b_done),
        .err       (b_err)
    );

    // Observe whichever instance the current step targets
    assign o_req_ready = use_b ? b_req_ready : a_req_ready;
    assign o_mem_valid = use_b ? b_mem_valid : a_mem_valid;
    assign o_mem_addr  = use_b ? b_mem_addr  : a_mem_addr;
    assign o_mem_wdata = use_b ? b_mem_wdata : a_mem_wdata;
    assign o_mem_wstrb = use_b ? b_mem_wstrb : a_mem_wstrb;
    assign o_done      = use_b ? b_done      : a_done;
    assign o_err       = use_b ? b_err       : a_err;

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something escapes the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic push_beat(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        beat_t b;
        b.addr = addr;
        b.data = data;
        b.strb = strb;
        beat_q.push_back(b);
    endtask

    // Drive one store, then watch beats and done; mem_ready is low for the first 'stall' cycles after accept
    task automatic applyStimulus(input string tag, input logic sel_b, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [1:0] size, input int stall,
                                 input int exp_done_k, input logic exp_err);
        bit   seen_done;
        logic e;
        @(posedge clk);
        #1;
        use_b     = sel_b;
        mem_ready = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        if (sel_b) req_valid_b = 1'b1;
        else       req_valid_a = 1'b1;
        err_q.push_back(exp_err);
        @(negedge clk);
        checkOutput({tag, "/req_ready_idle"}, {31'b0, o_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_addr    = 32'hDEAD_BEEF;
        req_data    = 32'h0BAD_0BAD;
        seen_done   = 1'b0;
        for (int k = 1; k <= 20 && !seen_done; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            mem_ready = (k > stall);
            @(negedge clk);
            if (o_mem_valid) begin
                if (beat_q.size() == 0) begin
                    checkOutput({tag, "/spurious_beat"}, {31'b0, o_mem_valid}, 32'd0);
                end else begin
                    checkOutput({tag, "/addr"}, o_mem_addr, beat_q[0].addr);
                    checkOutput({tag, "/wdata"}, o_mem_wdata, beat_q[0].data);
                    checkOutput({tag, "/wstrb"}, {28'b0, o_mem_wstrb}, {28'b0, beat_q[0].strb});
                    if (mem_ready) void'(beat_q.pop_front());
                end
            end
            if (o_done) begin
                seen_done = 1'b1;
                e = err_q.pop_front();
                checkOutput({tag, "/err"}, {31'b0, o_err}, {31'b0, e});
                checkOutput({tag, "/done_cycle"}, k, exp_done_k);
                checkOutput({tag, "/req_ready_busy"}, {31'b0, o_req_ready}, 32'd0);
                checkOutput({tag, "/valid_at_done"}, {31'b0, o_mem_valid}, 32'd0);
            end else begin
                checkOutput({tag, "/err_low"}, {31'b0, o_err}, 32'd0);
            end
        end
        checkOutput({tag, "/done_seen"}, {31'b0, seen_done}, 32'd1);
        checkOutput({tag, "/beats_left"}, beat_q.size(), 32'd0);
        beat_q.delete();
        err_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({tag, "/req_ready_after"}, {31'b0, o_req_ready}, 32'd1);
        checkOutput({tag, "/done_single"}, {31'b0, o_done}, 32'd0);
    endtask

    // Directed sequence of stores, then an asynchronous reset mid-beat
    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        mem_ready   = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_addr    = '0;
        req_data    = '0;
        req_size    = '0;
        use_b       = 1'b0;

        #3;
        checkOutput("reset/req_ready", {31'b0, a_req_ready}, 32'd1);
        checkOutput("reset/mem_valid", {31'b0, a_mem_valid}, 32'd0);
        checkOutput("reset/mem_addr", a_mem_addr, 32'd0);
        checkOutput("reset/mem_wdata", a_mem_wdata, 32'd0);
        checkOutput("reset/mem_wstrb", {28'b0, a_mem_wstrb}, 32'd0);
        checkOutput("reset/done", {31'b0, a_done}, 32'd0);
        checkOutput("reset/err", {31'b0, a_err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] byte store, top lane");
        push_beat(32'h0000_1000, 32'hDD00_0000, 4'b1000);
        applyStimulus("byte_1003", 1'b0, 32'h0000_1003, 32'hAABB_CCDD, 2'b00, 0, 2, 1'b0);

        $display("[TB] byte store, lane 1");
        push_beat(32'h0000_5000, 32'h0000_A500, 4'b0010);
        applyStimulus("byte_5001", 1'b0, 32'h0000_5001, 32'hFFFF_FFA5, 2'b00, 0, 2, 1'b0);

        $display("[TB] half store, upper half");
        push_beat(32'h0000_2000, 32'h5678_0000, 4'b1100);
        applyStimulus("half_2002", 1'b0, 32'h0000_2002, 32'h1234_5678, 2'b01, 0, 2, 1'b0);

        $display("[TB] split word store with 3-cycle stall on beat0");
        push_beat(32'h0000_3000, 32'h2233_4400, 4'b1110);
        push_beat(32'h0000_3004, 32'h0000_0011, 4'b0001);
        applyStimulus("word_3001_stall", 1'b0, 32'h0000_3001, 32'h1122_3344, 2'b10, 3, 6, 1'b0);

        $display("[TB] split word store, no stall");
        push_beat(32'h0000_3000, 32'h2233_4400, 4'b1110);
        push_beat(32'h0000_3004, 32'h0000_0011, 4'b0001);
        applyStimulus("word_3001", 1'b0, 32'h0000_3001, 32'h1122_3344, 2'b10, 0, 3, 1'b0);

        $display("[TB] split half store wrapping past top of address space");
        push_beat(32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000);
        push_beat(32'h0000_0000, 32'h0000_00BE, 4'b0001);
        applyStimulus("half_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01, 0, 3, 1'b0);

        $display("[TB] invalid size rejected");
        applyStimulus("size_11", 1'b0, 32'h0000_1000, 32'h1234_5678, 2'b11, 0, 1, 1'b1);

        $display("[TB] crossing store rejected when splitting disabled");
        applyStimulus("nosplit_3001", 1'b1, 32'h0000_3001, 32'h1122_3344, 2'b10, 0, 1, 1'b1);

        $display("[TB] aligned word on non-splitting instance");
        push_beat(32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
        applyStimulus("nosplit_4000", 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 2'b10, 0, 2, 1'b0);

        $display("[TB] async reset while holding beat1");
        use_b = 1'b0;
        @(posedge clk);
        #1;
        mem_ready   = 1'b1;
        req_addr    = 32'h0000_3001;
        req_data    = 32'h1122_3344;
        req_size    = 2'b10;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        mem_ready   = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid/beat1_valid", {31'b0, a_mem_valid}, 32'd1);
        checkOutput("rst_mid/beat1_addr", a_mem_addr, 32'h0000_3004);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid/valid_drop", {31'b0, a_mem_valid}, 32'd0);
        checkOutput("rst_mid/wstrb_clear", {28'b0, a_mem_wstrb}, 32'd0);
        checkOutput("rst_mid/done", {31'b0, a_done}, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("rst_mid/no_done", {31'b0, a_done}, 32'd0);
            checkOutput("rst_mid/no_valid", {31'b0, a_mem_valid}, 32'd0);
            checkOutput("rst_mid/req_ready", {31'b0, a_req_ready}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
